// File: rtl/mult_digit_sequencer_if.sv
// Requester and multiplier-core signals of the digit-serial multiplier sequencer.
// "slave" is the sequencer's view; "master" is the requester plus the 2x2 core.
interface mult_digit_sequencer_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic [1:0]           mul_a;
  logic [1:0]           mul_b;
  logic [3:0]           mul_c;

  modport master (
    output start, a, b, mul_c,
    input  busy, done, product, mul_a, mul_b
  );

  modport slave (
    input  start, a, b, mul_c,
    output busy, done, product, mul_a, mul_b
  );
endinterface

// File: rtl/mult_digit_sequencer.sv
// Radix-4 digit-serial WIDTHxWIDTH unsigned multiplier that time-shares one
// external combinational 2x2 core, one partial product per clock.
module mult_digit_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mult_digit_sequencer_if.slave bus
);
  localparam int N  = WIDTH / 2;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_reg;
  logic [WIDTH-1:0]     a_reg, b_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [2*WIDTH-1:0]   product_reg;
  logic [IW-1:0]        i_reg, j_reg;
  logic                 busy_reg, done_reg;
  logic [2*WIDTH-1:0]   pp_next;
  logic [1:0]           mul_a_next, mul_b_next;

  // Core result shifted to its weight: digit i of a times digit j of b.
  always_comb begin
    pp_next = (2*WIDTH)'(bus.mul_c) << (2 * (int'(i_reg) + int'(j_reg)));
  end

  always_comb begin
    mul_a_next = '0;
    mul_b_next = '0;
    if (state_reg == RUN) begin
      mul_a_next = a_reg[2*int'(i_reg) +: 2];
      mul_b_next = b_reg[2*int'(j_reg) +: 2];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      acc_reg     <= '0;
      product_reg <= '0;
      i_reg       <= '0;
      j_reg       <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            acc_reg   <= '0;
            i_reg     <= '0;
            j_reg     <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          acc_reg <= acc_reg + pp_next;
          // j is the fast digit index; i advances when j wraps.
          if (j_reg == LAST) begin
            j_reg <= '0;
            if (i_reg == LAST) begin
              i_reg     <= '0;
              state_reg <= DONE;
            end else begin
              i_reg <= i_reg + IW'(1);
            end
          end else begin
            j_reg <= j_reg + IW'(1);
          end
        end
        DONE: begin
          product_reg <= acc_reg;
          done_reg    <= 1'b1;
          busy_reg    <= 1'b0;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.product = product_reg;
  assign bus.mul_a   = mul_a_next;
  assign bus.mul_b   = mul_b_next;
endmodule

// File: tb/tb_mult_digit_sequencer.sv
// Directed and random checks of mult_digit_sequencer at WIDTH=8 and WIDTH=2,
// against plain a*b and the expected digit visiting order.
module tb_mult_digit_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mult_digit_sequencer_if #(.WIDTH(8)) s8 ();
  mult_digit_sequencer_if #(.WIDTH(2)) s2 ();

  // The 2x2 multiplier cores.
  assign s8.mul_c = 4'(s8.mul_a) * 4'(s8.mul_b);
  assign s2.mul_c = 4'(s2.mul_a) * 4'(s2.mul_b);

  mult_digit_sequencer #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(s8));
  mult_digit_sequencer #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(s2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation. hold keeps start high and scrambles a/b during the run.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input bit dig, input bit hold);
    int          edges;
    bit          got;
    logic [15:0] exp;
    exp = 16'(av) * 16'(bv);
    @(negedge clk);
    s8.start = 1'b1; s8.a = av; s8.b = bv;
    @(posedge clk); #1;
    if (hold) begin
      s8.a = ~av; s8.b = bv ^ 8'h5A;
    end else begin
      s8.start = 1'b0; s8.a = $urandom; s8.b = $urandom;
    end
    chk("busy_after_start", 32'(s8.busy), 32'd1);
    edges = 0; got = 1'b0;
    while (!got && edges < 100) begin
      if (dig && edges < 16) begin
        // step k visits digit pair (k/4, k%4): b's digit moves fastest
        chk($sformatf("mul_a_step%0d", edges), 32'(s8.mul_a), 32'((av >> (2 * (edges / 4))) & 8'h3));
        chk($sformatf("mul_b_step%0d", edges), 32'(s8.mul_b), 32'((bv >> (2 * (edges % 4))) & 8'h3));
      end
      @(posedge clk); #1;
      edges++;
      if (s8.done) got = 1'b1;
    end
    s8.start = 1'b0;
    chk("done_seen", 32'(got), 32'd1);
    chk("done_latency", 32'(edges), 32'd17);
    chk($sformatf("product_%02h_x_%02h", av, bv), 32'(s8.product), 32'(exp));
    $display("op8 a=%02h b=%02h product=%04h expected=%04h edges=%0d", av, bv, s8.product, exp, edges);
    @(posedge clk); #1;
    chk("busy_after_done", 32'(s8.busy), 32'd0);
    chk("done_one_cycle", 32'(s8.done), 32'd0);
    chk("product_holds", 32'(s8.product), 32'(exp));
  endtask

  task automatic op2(input logic [1:0] av, input logic [1:0] bv);
    int  edges;
    bit  got;
    @(negedge clk);
    s2.start = 1'b1; s2.a = av; s2.b = bv;
    @(posedge clk); #1;
    s2.start = 1'b0;
    edges = 0; got = 1'b0;
    while (!got && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (s2.done) got = 1'b1;
    end
    chk("w2_done_seen", 32'(got), 32'd1);
    chk("w2_done_latency", 32'(edges), 32'd2);
    chk($sformatf("w2_product_%0d_x_%0d", av, bv), 32'(s2.product), 32'(av) * 32'(bv));
    $display("op2 a=%0d b=%0d product=%0h edges=%0d", av, bv, s2.product, edges);
  endtask

  initial begin
    s8.start = 1'b0; s8.a = '0; s8.b = '0;
    s2.start = 1'b0; s2.a = '0; s2.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(s8.busy), 32'd0);
    chk("rst_done", 32'(s8.done), 32'd0);
    chk("rst_product", 32'(s8.product), 32'd0);
    chk("rst_mul_a", 32'(s8.mul_a), 32'd0);
    chk("rst_mul_b", 32'(s8.mul_b), 32'd0);
    chk("rst_w2_product", 32'(s2.product), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Maximum operands, then back-to-back runs.
    op8(8'hFF, 8'hFF, 1'b0, 1'b0);
    op8(8'hA5, 8'h3C, 1'b0, 1'b0);
    op8(8'h00, 8'h7F, 1'b0, 1'b0);

    // Start held through the run with changing operands is ignored.
    op8(8'h12, 8'h34, 1'b0, 1'b1);
    op8(8'h21, 8'h43, 1'b0, 1'b0);

    // Reset in the 8th RUN cycle aborts the operation.
    @(negedge clk);
    s8.start = 1'b1; s8.a = 8'h11; s8.b = 8'h22;
    @(posedge clk); #1;
    s8.start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", 32'(s8.busy), 32'd0);
    chk("abort_done", 32'(s8.done), 32'd0);
    chk("abort_product", 32'(s8.product), 32'd0);
    chk("abort_mul_a", 32'(s8.mul_a), 32'd0);
    chk("abort_mul_b", 32'(s8.mul_b), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      chk("abort_no_done", 32'(s8.done), 32'd0);
    end
    op8(8'h03, 8'h05, 1'b0, 1'b0);

    // WIDTH=2 exhaustive.
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        op2(2'(x), 2'(y));

    // Random WIDTH=8 pairs; digit order checked on the first.
    for (int k = 0; k < 200; k++)
      op8(8'($urandom), 8'($urandom), k == 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
